// File: rtl/vector_int_divide_stage_if.sv
// Handshake bundle between operand fetch, the vector divide unit and writeback.
// The master side is the issuer/writeback pair; the slave side is the divide unit.
interface vector_int_divide_stage_if #(
  parameter int unsigned NUM_LANES        = 16,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned THREAD_IDX_WIDTH = 2
);
  logic                              id_valid;
  logic                              id_ready;
  logic [1:0]                        id_op;
  logic [NUM_LANES*DATA_WIDTH-1:0]   id_dividend;
  logic [NUM_LANES*DATA_WIDTH-1:0]   id_divisor;
  logic [NUM_LANES-1:0]              id_mask;
  logic [THREAD_IDX_WIDTH-1:0]       id_thread_idx;
  logic                              wb_rollback_en;
  logic [THREAD_IDX_WIDTH-1:0]       wb_rollback_thread_idx;
  logic                              dv_valid;
  logic                              dv_ready;
  logic [NUM_LANES*DATA_WIDTH-1:0]   dv_result;
  logic [NUM_LANES-1:0]              dv_mask;
  logic [THREAD_IDX_WIDTH-1:0]       dv_thread_idx;
  logic [NUM_LANES-1:0]              dv_div_by_zero;

  modport master (
    output id_valid, id_op, id_dividend, id_divisor, id_mask, id_thread_idx,
           wb_rollback_en, wb_rollback_thread_idx, dv_ready,
    input  id_ready, dv_valid, dv_result, dv_mask, dv_thread_idx, dv_div_by_zero
  );

  modport slave (
    input  id_valid, id_op, id_dividend, id_divisor, id_mask, id_thread_idx,
           wb_rollback_en, wb_rollback_thread_idx, dv_ready,
    output id_ready, dv_valid, dv_result, dv_mask, dv_thread_idx, dv_div_by_zero
  );
endinterface

// File: rtl/vector_int_divide_stage.sv
// Multi-cycle vector integer divide/remainder unit: radix-2 restoring division on
// every enabled lane in parallel, with thread-matched rollback squash.
module vector_int_divide_stage #(
  parameter int unsigned NUM_LANES        = 16,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned THREAD_IDX_WIDTH = 2
) (
  input logic                    clk,
  input logic                    reset,
  vector_int_divide_stage_if.slave bus
);
  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, PREP, ITERATE, FIXUP, DONE} state_t;

  state_t                          state;
  logic [1:0]                      op;
  logic [THREAD_IDX_WIDTH-1:0]     thread;
  logic [NUM_LANES-1:0]            mask;
  logic [NUM_LANES-1:0]            neg_q;
  logic [NUM_LANES-1:0]            neg_r;
  logic [NUM_LANES-1:0]            dz;
  logic [NUM_LANES-1:0][W-1:0]     dividend;
  logic [NUM_LANES-1:0][W-1:0]     divisor;
  logic [NUM_LANES-1:0][W-1:0]     rem;
  logic [NUM_LANES-1:0][W-1:0]     quo;
  logic [CNT_W-1:0]                cnt;

  logic                            id_ready_r;
  logic [NUM_LANES-1:0][W-1:0]     result_r;
  logic [NUM_LANES-1:0]            mask_r;
  logic [NUM_LANES-1:0]            dz_r;
  logic [THREAD_IDX_WIDTH-1:0]     thread_r;

  logic                            signed_op_c;
  logic                            rollback_hit_c;
  logic [NUM_LANES-1:0]            a_neg_c;
  logic [NUM_LANES-1:0]            b_neg_c;
  logic [NUM_LANES-1:0]            dz_c;
  logic [NUM_LANES-1:0][W-1:0]     abs_a_c;
  logic [NUM_LANES-1:0][W-1:0]     abs_b_c;
  logic [NUM_LANES-1:0][W-1:0]     rem_step_c;
  logic [NUM_LANES-1:0][W-1:0]     quo_step_c;
  logic [NUM_LANES-1:0][W-1:0]     result_c;

  assign signed_op_c    = op[0];
  assign rollback_hit_c = bus.wb_rollback_en && (bus.wb_rollback_thread_idx == thread);

  // Per-lane magnitude prep, one restoring step, and sign/zero fixup.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [W:0]   shifted;
    logic         ge;
    logic [W-1:0] quo_fix;
    logic [W-1:0] rem_fix;

    assign a_neg_c[i] = signed_op_c && dividend[i][W-1];
    assign b_neg_c[i] = signed_op_c && divisor[i][W-1];
    assign abs_a_c[i] = a_neg_c[i] ? W'(-dividend[i]) : dividend[i];
    assign abs_b_c[i] = b_neg_c[i] ? W'(-divisor[i]) : divisor[i];
    assign dz_c[i]    = (divisor[i] == '0);

    assign shifted       = {rem[i], quo[i][W-1]};
    assign ge            = (shifted >= {1'b0, divisor[i]});
    assign rem_step_c[i] = ge ? (shifted[W-1:0] - divisor[i]) : shifted[W-1:0];
    assign quo_step_c[i] = {quo[i][W-2:0], ge};

    // Divide-by-zero bypasses sign fixup: all-ones quotient, original dividend.
    assign quo_fix = dz[i] ? '1 : (neg_q[i] ? W'(-quo[i]) : quo[i]);
    assign rem_fix = dz[i] ? dividend[i] : (neg_r[i] ? W'(-rem[i]) : rem[i]);
    assign result_c[i] = !mask[i] ? '0 : (op[1] ? rem_fix : quo_fix);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      op         <= '0;
      thread     <= '0;
      mask       <= '0;
      neg_q      <= '0;
      neg_r      <= '0;
      dz         <= '0;
      dividend   <= '0;
      divisor    <= '0;
      rem        <= '0;
      quo        <= '0;
      cnt        <= '0;
      id_ready_r <= 1'b1;
      result_r   <= '0;
      mask_r     <= '0;
      dz_r       <= '0;
      thread_r   <= '0;
    end else if ((state != IDLE) && rollback_hit_c) begin
      state      <= IDLE;
      id_ready_r <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.id_valid) begin
            state      <= PREP;
            id_ready_r <= 1'b0;
            op         <= bus.id_op;
            dividend   <= bus.id_dividend;
            divisor    <= bus.id_divisor;
            mask       <= bus.id_mask;
            thread     <= bus.id_thread_idx;
          end
        end
        PREP: begin
          quo     <= abs_a_c;
          divisor <= abs_b_c;
          neg_q   <= a_neg_c ^ b_neg_c;
          neg_r   <= a_neg_c;
          dz      <= dz_c;
          rem     <= '0;
          cnt     <= CNT_LAST;
          state   <= ITERATE;
        end
        ITERATE: begin
          rem <= rem_step_c;
          quo <= quo_step_c;
          if (cnt == '0) state <= FIXUP;
          else           cnt   <= cnt - CNT_W'(1);
        end
        FIXUP: begin
          result_r <= result_c;
          mask_r   <= mask;
          dz_r     <= dz & mask;
          thread_r <= thread;
          state    <= DONE;
        end
        DONE: begin
          if (bus.dv_ready) begin
            state      <= IDLE;
            id_ready_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.id_ready       = id_ready_r;
  assign bus.dv_valid       = (state == DONE) && !rollback_hit_c;
  assign bus.dv_result      = result_r;
  assign bus.dv_mask        = mask_r;
  assign bus.dv_thread_idx  = thread_r;
  assign bus.dv_div_by_zero = dz_r;

endmodule

// File: tb/tb_vector_int_divide_stage.sv
// Directed bench for vector_int_divide_stage: latency, signed/unsigned results,
// divide-by-zero, masking, backpressure, rollback, mid-op reset and a short random mix.
module tb_vector_int_divide_stage;
  localparam int unsigned NL = 16;
  localparam int unsigned W  = 32;
  localparam int unsigned TW = 2;
  localparam int unsigned VW = NL * W;
  localparam logic [W-1:0] MIN = 32'h8000_0000;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   lat;
  logic [VW-1:0] va, vb, ve, held;
  logic [NL-1:0] rmask;
  logic [1:0]    rop;
  logic          saw;

  vector_int_divide_stage_if #(.NUM_LANES(NL), .DATA_WIDTH(W), .THREAD_IDX_WIDTH(TW)) bus ();

  vector_int_divide_stage #(.NUM_LANES(NL), .DATA_WIDTH(W), .THREAD_IDX_WIDTH(TW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                       input logic [NL-1:0] m, input logic [TW-1:0] tid);
    for (int i = 0; i < 100 && !bus.id_ready; i++) tick();
    chk("issue_ready", VW'(bus.id_ready), VW'(1));
    bus.id_op         = op;
    bus.id_dividend   = a;
    bus.id_divisor    = b;
    bus.id_mask       = m;
    bus.id_thread_idx = tid;
    bus.id_valid      = 1'b1;
    tick();
    bus.id_valid      = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.dv_valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic xfer();
    bus.dv_ready = 1'b1;
    tick();
    bus.dv_ready = 1'b0;
    chk("xfer_valid_low", VW'(bus.dv_valid), VW'(0));
    chk("xfer_ready_high", VW'(bus.id_ready), VW'(1));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_id_ready"}, VW'(bus.id_ready), VW'(1));
    chk({tag, "_dv_valid"}, VW'(bus.dv_valid), VW'(0));
    chk({tag, "_dv_result"}, bus.dv_result, '0);
    chk({tag, "_dv_mask"}, VW'(bus.dv_mask), VW'(0));
    chk({tag, "_dv_thread"}, VW'(bus.dv_thread_idx), VW'(0));
    chk({tag, "_dv_dz"}, VW'(bus.dv_div_by_zero), VW'(0));
  endtask

  function automatic logic [W-1:0] ref_lane(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    if (b == '0) return op[1] ? a : '1;
    if (!op[0]) return op[1] ? (a % b) : (a / b);
    if (a == MIN && b == '1) return op[1] ? '0 : MIN;
    return op[1] ? W'($signed(a) % $signed(b)) : W'($signed(a) / $signed(b));
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return MIN;
      3:       return W'($urandom_range(1, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    bus.id_valid = 1'b0; bus.id_op = '0; bus.id_dividend = '0; bus.id_divisor = '0;
    bus.id_mask = '0; bus.id_thread_idx = '0; bus.wb_rollback_en = 1'b0;
    bus.wb_rollback_thread_idx = '0; bus.dv_ready = 1'b0;
    tick(); tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();

    // DIVU 100/7 on all lanes, latency check
    issue(2'b00, {NL{32'd100}}, {NL{32'd7}}, 16'hFFFF, 2'd0);
    wait_done(lat);
    chk("divu_latency", VW'(lat), VW'(34));
    chk("divu_result", bus.dv_result, {NL{32'd14}});
    chk("divu_dz", VW'(bus.dv_div_by_zero), VW'(0));
    chk("divu_mask", VW'(bus.dv_mask), VW'(16'hFFFF));
    chk("divu_busy", VW'(bus.id_ready), VW'(0));
    xfer();

    // Signed REMS / DIVS, masked to lanes 0..2
    va = {NL{32'd55}}; vb = {NL{32'd5}};
    va[0*W +: W] = 32'hFFFF_FFF9; vb[0*W +: W] = 32'd2;
    va[1*W +: W] = 32'd7;         vb[1*W +: W] = 32'hFFFF_FFFE;
    va[2*W +: W] = MIN;           vb[2*W +: W] = 32'hFFFF_FFFF;
    issue(2'b11, va, vb, 16'h0007, 2'd1);
    wait_done(lat);
    ve = '0; ve[0*W +: W] = 32'hFFFF_FFFF; ve[1*W +: W] = 32'd1; ve[2*W +: W] = 32'd0;
    chk("rems_result", bus.dv_result, ve);
    chk("rems_thread", VW'(bus.dv_thread_idx), VW'(1));
    chk("rems_dz", VW'(bus.dv_div_by_zero), VW'(0));
    xfer();
    issue(2'b01, va, vb, 16'h0007, 2'd1);
    wait_done(lat);
    ve = '0; ve[0*W +: W] = 32'hFFFF_FFFD; ve[1*W +: W] = 32'hFFFF_FFFD; ve[2*W +: W] = MIN;
    chk("divs_result", bus.dv_result, ve);
    xfer();

    // DIVU 5/0 on lane 0; lane 1 also /0 but masked off
    va = '0; vb = '0; va[0*W +: W] = 32'd5; va[1*W +: W] = 32'd10;
    issue(2'b00, va, vb, 16'h0001, 2'd3);
    wait_done(lat);
    ve = '0; ve[0*W +: W] = 32'hFFFF_FFFF;
    chk("dz_divu_result", bus.dv_result, ve);
    chk("dz_divu_flag", VW'(bus.dv_div_by_zero), VW'(16'h0001));
    chk("dz_thread", VW'(bus.dv_thread_idx), VW'(3));
    // Backpressure: outputs hold while dv_ready is low
    held = bus.dv_result;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bus.dv_valid || bus.id_ready || bus.dv_result !== held) saw = 1'b1;
    end
    chk("bp_stable", VW'(saw), VW'(0));
    chk("bp_result", bus.dv_result, ve);
    xfer();

    // REMS -9/0 flags and returns dividend; -9 rem 4 = -1
    va = '0; vb = '0; va[0*W +: W] = 32'hFFFF_FFF7; va[1*W +: W] = 32'hFFFF_FFF7;
    vb[1*W +: W] = 32'd4;
    issue(2'b11, va, vb, 16'h0003, 2'd0);
    wait_done(lat);
    ve = '0; ve[0*W +: W] = 32'hFFFF_FFF7; ve[1*W +: W] = 32'hFFFF_FFFF;
    chk("dz_rems_result", bus.dv_result, ve);
    chk("dz_rems_flag", VW'(bus.dv_div_by_zero), VW'(16'h0001));
    xfer();

    // Unsigned full-width operands
    va = '0; vb = '0; va[0*W +: W] = 32'hFFFF_FFFF; vb[0*W +: W] = 32'h10;
    va[1*W +: W] = MIN; vb[1*W +: W] = 32'hFFFF_FFFF;
    issue(2'b00, va, vb, 16'h0003, 2'd0);
    wait_done(lat);
    ve = '0; ve[0*W +: W] = 32'h0FFF_FFFF; ve[1*W +: W] = 32'd0;
    chk("divu_wide", bus.dv_result, ve);
    xfer();
    issue(2'b10, va, vb, 16'h0003, 2'd0);
    wait_done(lat);
    ve = '0; ve[0*W +: W] = 32'hF; ve[1*W +: W] = MIN;
    chk("remu_wide", bus.dv_result, ve);
    xfer();

    // Rollback of the issuing thread mid-ITERATE squashes the op
    issue(2'b00, {NL{32'd100}}, {NL{32'd7}}, 16'hFFFF, 2'd2);
    for (int i = 0; i < 9; i++) tick();
    bus.wb_rollback_en = 1'b1; bus.wb_rollback_thread_idx = 2'd2;
    tick();
    bus.wb_rollback_en = 1'b0;
    chk("rb_ready", VW'(bus.id_ready), VW'(1));
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.dv_valid) saw = 1'b1;
      tick();
    end
    chk("rb_no_valid", VW'(saw), VW'(0));

    // Rollback of another thread is ignored
    issue(2'b00, {NL{32'd100}}, {NL{32'd7}}, 16'hFFFF, 2'd2);
    for (int i = 0; i < 9; i++) tick();
    bus.wb_rollback_en = 1'b1; bus.wb_rollback_thread_idx = 2'd1;
    tick();
    bus.wb_rollback_en = 1'b0;
    chk("rb_other_busy", VW'(bus.id_ready), VW'(0));
    wait_done(lat);
    chk("rb_other_latency", VW'(lat), VW'(24));
    chk("rb_other_result", bus.dv_result, {NL{32'd14}});
    xfer();

    // Rollback in DONE gates dv_valid combinationally
    issue(2'b00, {NL{32'd100}}, {NL{32'd7}}, 16'hFFFF, 2'd2);
    wait_done(lat);
    bus.wb_rollback_en = 1'b1; bus.wb_rollback_thread_idx = 2'd3;
    #1;
    chk("rb_done_other", VW'(bus.dv_valid), VW'(1));
    bus.wb_rollback_thread_idx = 2'd2; bus.dv_ready = 1'b1;
    #1;
    chk("rb_done_gate", VW'(bus.dv_valid), VW'(0));
    tick();
    bus.wb_rollback_en = 1'b0; bus.dv_ready = 1'b0;
    chk("rb_done_idle", VW'(bus.id_ready), VW'(1));
    chk("rb_done_after", VW'(bus.dv_valid), VW'(0));

    // Random mix against a native-arithmetic reference
    for (int n = 0; n < 24; n++) begin
      rop = 2'($urandom_range(0, 3));
      rmask = NL'($urandom);
      ve = '0;
      for (int i = 0; i < NL; i++) begin
        va[i*W +: W] = rnd_val();
        vb[i*W +: W] = rnd_val();
        if (rmask[i]) ve[i*W +: W] = ref_lane(rop, va[i*W +: W], vb[i*W +: W]);
      end
      issue(rop, va, vb, rmask, 2'($urandom_range(0, 3)));
      wait_done(lat);
      chk("rand_result", bus.dv_result, ve);
      xfer();
    end

    // Reset mid-ITERATE returns all outputs to reset values
    issue(2'b00, {NL{32'd100}}, {NL{32'd7}}, 16'hFFFF, 2'd1);
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    tick();
    reset = 1'b0;
    tick();
    chk("midrst_after", VW'(bus.id_ready), VW'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
